// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory pipeline stage: bus request FSM, load alignment/extension, store strobes (option: MEM_MISALIGN_TRAP_EN)
package memory_stage_pkg;
    typedef enum logic [1:0] {OP_ALU, OP_LD, OP_SD, OP_BR} mem_op_t;

    typedef struct packed {
        mem_op_t op;
        logic    regwrite;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        valid;
        logic [31:0] raw_instr;
        ctl_t        ctl;
        logic [4:0]  dst;
        logic [63:0] rd2;
        logic [63:0] result;
        logic [11:0] csrdst;
        logic [63:0] csr;
        logic [3:0]  error;
    } excute_data_t;

    typedef excute_data_t memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  dst;
        logic        ismem;
    } tran_t;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int AXI_WIDTH = 64,
    parameter int ADDR_LSB  = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    input  logic         stopw,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output memory_data_t dataM,
    output logic         stopm,
    output tran_t        tranm
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t                  state, state_n;
    logic [AXI_WIDTH-1:0]    rdata_q;
    logic [AXI_WIDTH-1:0]    raw, shifted;
    logic [63:0]             ld_data, eff_addr;
    logic [2:0]              funct3, align_mask;
    logic [ADDR_LSB-1:0]     off;
    logic [ADDR_LSB+2:0]     shamt;
    logic [7:0]              size_mask;
    logic                    is_ld, is_sd, mem_op, trap, req_op, beat_ok, op_done;
    logic                    unused_addr_ok;

    assign unused_addr_ok = dresp.addr_ok;
    assign funct3 = dataE.raw_instr[14:12];
    assign is_ld  = dataE.ctl.op == OP_LD;
    assign is_sd  = dataE.ctl.op == OP_SD;
    assign mem_op = dataE.valid && dataE.error == 4'd0 && (is_ld || is_sd);

    always_comb begin
        align_mask = 3'b000;
        size_mask  = 8'h01;
        case (funct3[1:0])
            2'b01:   begin align_mask = 3'b001; size_mask = 8'h03; end
            2'b10:   begin align_mask = 3'b011; size_mask = 8'h0F; end
            2'b11:   begin align_mask = 3'b111; size_mask = 8'hFF; end
            default: begin align_mask = 3'b000; size_mask = 8'h01; end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign eff_addr = dataE.result;
    assign trap     = mem_op && (|(dataE.result[2:0] & align_mask));
`else
    assign eff_addr = dataE.result & ~{61'd0, align_mask};
    assign trap     = 1'b0;
`endif

    assign off     = eff_addr[ADDR_LSB-1:0];
    assign shamt   = {off, 3'b000};
    assign req_op  = mem_op && !trap;
    assign beat_ok = req_op && state != HOLD && dresp.data_ok;
    // HOLD means the beat already landed in rdata_q while writeback was stalled.
    assign op_done = beat_ok || state == HOLD || trap;

    assign raw     = beat_ok ? dresp.data : rdata_q;
    assign shifted = raw >> shamt;

    always_comb begin
        ld_data = shifted;
        case (funct3)
            3'b000:  ld_data = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  ld_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  ld_data = {56'd0, shifted[7:0]};
            3'b101:  ld_data = {48'd0, shifted[15:0]};
            3'b110:  ld_data = {32'd0, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = req_op && state != HOLD && !reset;
        dreq.addr   = eff_addr;
        dreq.size   = {1'b0, funct3[1:0]};
        dreq.strobe = is_sd ? (size_mask << off) : 8'h00;
        dreq.data   = is_sd ? (dataE.rd2 << shamt) : 64'd0;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (req_op) state_n = dresp.data_ok ? (stopw ? HOLD : IDLE) : WAIT;
            WAIT: if (dresp.data_ok) state_n = stopw ? HOLD : IDLE;
            HOLD: if (!stopw) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (beat_ok) rdata_q <= dresp.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataM <= '0;
        end else if (!stopw) begin
            if (mem_op && !op_done) begin
                dataM.valid <= 1'b0;
            end else begin
                dataM <= dataE;
                if (is_ld && req_op) dataM.result <= ld_data;
                if (trap) dataM.error <= is_ld ? 4'd4 : 4'd6;
            end
        end
    end

    assign stopm = !reset && ((mem_op && !op_done) || stopw);

    always_comb begin
        tranm       = '0;
        tranm.data  = (is_ld && req_op && op_done) ? ld_data : dataE.result;
        tranm.dst   = (!reset && dataE.ctl.regwrite && dataE.valid && dataE.error == 4'd0 && !trap)
                      ? dataE.dst : 5'd0;
        tranm.ismem = mem_op && is_ld && !op_done;
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic         clk, reset, stopw, stopm;
    excute_data_t dataE;
    memory_data_t dataM;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    tran_t        tranm;

    memory_stage dut (
        .clk(clk), .reset(reset), .dataE(dataE), .stopw(stopw), .dreq(dreq),
        .dresp(dresp), .dataM(dataM), .stopm(stopm), .tranm(tranm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mem_op_t     op;
        logic [2:0]  f3;
        logic [63:0] addr, rd2, rdata;
        logic        rw;
        logic [4:0]  dst;
        logic [3:0]  err;
        logic        e_valid;
        logic [63:0] e_addr;
        logic [7:0]  e_strobe;
        logic [63:0] e_wdata;
        logic [2:0]  e_size;
        logic [63:0] e_result;
        logic [3:0]  e_err;
        logic [4:0]  e_tdst;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic [3:0]  err;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got result %h expected an entry", name, dataM.result);
        end else begin
            checks--;
            e = sb.pop_front();
            chk({name, "_valid"}, 64'(dataM.valid), 64'd1);
            chk({name, "_result"}, dataM.result, e.result);
            chk({name, "_error"}, 64'(dataM.error), 64'(e.err));
        end
    endtask

    task automatic drive_e(input logic v, input mem_op_t op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] rd2,
                           input logic rw, input logic [4:0] dst, input logic [3:0] err);
        dataE              = '0;
        dataE.pc           = 64'h8000_1000;
        dataE.valid        = v;
        dataE.raw_instr    = {17'd0, f3, 12'h003};
        dataE.ctl.op       = op;
        dataE.ctl.regwrite = rw;
        dataE.dst          = dst;
        dataE.rd2          = rd2;
        dataE.result       = addr;
        dataE.error        = err;
    endtask

    function automatic vec_t mk(mem_op_t op, logic [2:0] f3, logic [63:0] addr, logic [63:0] rd2,
                                logic [63:0] rdata, logic rw, logic [4:0] dst, logic [3:0] err,
                                logic e_valid, logic [63:0] e_addr, logic [7:0] e_strobe,
                                logic [63:0] e_wdata, logic [2:0] e_size, logic [63:0] e_result,
                                logic [3:0] e_err, logic [4:0] e_tdst);
        vec_t v;
        v.op = op; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.rdata = rdata; v.rw = rw;
        v.dst = dst; v.err = err; v.e_valid = e_valid; v.e_addr = e_addr; v.e_strobe = e_strobe;
        v.e_wdata = e_wdata; v.e_size = e_size; v.e_result = e_result; v.e_err = e_err;
        v.e_tdst = e_tdst;
        return v;
    endfunction

    initial begin
        int cnt;
        exp_t e;

        vecs[0]  = mk(OP_ALU, 3'b000, 64'h1234, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 64'h1234, 0, 5);
        vecs[1]  = mk(OP_SD, 3'b001, 64'h8000_0006, 64'hBEEF, 0, 0, 0, 0,
                      1, 64'h8000_0006, 8'hC0, 64'hBEEF_0000_0000_0000, 3'd1, 64'h8000_0006, 0, 0);
        vecs[2]  = mk(OP_LD, 3'b000, 64'h8000_0003, 0, 64'h0000_0000_80FF_0000, 1, 10, 0,
                      1, 64'h8000_0003, 8'h00, 0, 3'd0, 64'hFFFF_FFFF_FFFF_FF80, 0, 10);
        vecs[3]  = mk(OP_LD, 3'b110, 64'h8000_0004, 0, 64'h8000_0001_1234_5678, 1, 10, 0,
                      1, 64'h8000_0004, 8'h00, 0, 3'd2, 64'h0000_0000_8000_0001, 0, 10);
        vecs[4]  = mk(OP_LD, 3'b011, 64'h8000_0008, 0, 64'h1122_3344_5566_7788, 1, 11, 0,
                      1, 64'h8000_0008, 8'h00, 0, 3'd3, 64'h1122_3344_5566_7788, 0, 11);
        vecs[5]  = mk(OP_LD, 3'b101, 64'h8000_0002, 0, 64'h0000_0000_ABCD_0000, 1, 12, 0,
                      1, 64'h8000_0002, 8'h00, 0, 3'd1, 64'h0000_0000_0000_ABCD, 0, 12);
        vecs[6]  = mk(OP_LD, 3'b001, 64'h8000_0006, 0, 64'h8001_0000_0000_0000, 1, 13, 0,
                      1, 64'h8000_0006, 8'h00, 0, 3'd1, 64'hFFFF_FFFF_FFFF_8001, 0, 13);
        vecs[7]  = mk(OP_SD, 3'b000, 64'h8000_0005, 64'hAA, 0, 0, 0, 0,
                      1, 64'h8000_0005, 8'h20, 64'h0000_AA00_0000_0000, 3'd0, 64'h8000_0005, 0, 0);
        vecs[8]  = mk(OP_SD, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 0, 0, 0, 0,
                      1, 64'h8000_0004, 8'hF0, 64'hDEAD_BEEF_0000_0000, 3'd2, 64'h8000_0004, 0, 0);
        vecs[9]  = mk(OP_SD, 3'b011, 64'h8000_0000, 64'h0102_0304_0506_0708, 0, 0, 0, 0,
                      1, 64'h8000_0000, 8'hFF, 64'h0102_0304_0506_0708, 3'd3, 64'h8000_0000, 0, 0);
        vecs[10] = mk(OP_LD, 3'b000, 64'h8000_0010, 0, 64'hFFFF, 1, 14, 3,
                      0, 0, 0, 0, 0, 64'h8000_0010, 3, 0);
        vecs[11] = mk(OP_LD, 3'b100, 64'h8000_0001, 0, 64'h0000_0000_0000_F000, 1, 15, 0,
                      1, 64'h8000_0001, 8'h00, 0, 3'd0, 64'h0000_0000_0000_00F0, 0, 15);
        vecs[12] = mk(OP_ALU, 3'b000, 64'h77, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 64'h77, 0, 9);
`ifdef MEM_MISALIGN_TRAP_EN
        vecs[13] = mk(OP_LD, 3'b010, 64'h8000_0002, 0, 64'h0000_0000_CAFE_BABE, 1, 7, 0,
                      0, 0, 0, 0, 0, 64'h8000_0002, 4, 0);
`else
        vecs[13] = mk(OP_LD, 3'b010, 64'h8000_0002, 0, 64'h0000_0000_CAFE_BABE, 1, 7, 0,
                      1, 64'h8000_0000, 8'h00, 0, 3'd2, 64'hFFFF_FFFF_CAFE_BABE, 0, 7);
`endif

        reset = 1'b1;
        stopw = 1'b0;
        dresp = '0;
        drive_e(1, OP_LD, 3'b000, 64'h8000_0000, 0, 1, 3, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dreq_valid", 64'(dreq.valid), 0);
        chk("rst_stopm", 64'(stopm), 0);
        chk("rst_tranm_dst", 64'(tranm.dst), 0);
        chk("rst_dataM_valid", 64'(dataM.valid), 0);
        drive_e(0, OP_ALU, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single-beat vectors: data_ok in the issue cycle, issued back to back
        for (int i = 0; i < 14; i++) begin
            drive_e(1, vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].rd2,
                    vecs[i].rw, vecs[i].dst, vecs[i].err);
            dresp.data_ok = 1'b1;
            dresp.data    = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_dreq_valid", i), 64'(dreq.valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_addr", i), dreq.addr, vecs[i].e_addr);
                chk($sformatf("v%0d_strobe", i), 64'(dreq.strobe), 64'(vecs[i].e_strobe));
                chk($sformatf("v%0d_size", i), 64'(dreq.size), 64'(vecs[i].e_size));
                if (vecs[i].op == OP_SD)
                    chk($sformatf("v%0d_wdata", i), dreq.data, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d_stopm", i), 64'(stopm), 0);
            chk($sformatf("v%0d_ismem", i), 64'(tranm.ismem), 0);
            chk($sformatf("v%0d_tranm_dst", i), 64'(tranm.dst), 64'(vecs[i].e_tdst));
            chk($sformatf("v%0d_tranm_data", i), tranm.data, vecs[i].e_result);
            e.result = vecs[i].e_result;
            e.err    = vecs[i].e_err;
            sb.push_back(e);
            @(posedge clk); #1;
            dresp.data_ok = 1'b0;
            pop_check($sformatf("v%0d_dataM", i));
        end

        // load answered two cycles late
        drive_e(1, OP_LD, 3'b000, 64'h8000_0003, 0, 1, 6, 0);
        dresp.data = 64'h0000_0000_80FF_0000;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            dresp.data_ok = (c == 2);
            #1;
            if (!stopm) break;
            cnt++;
            chk($sformatf("late_c%0d_dreq_valid", c), 64'(dreq.valid), 1);
            chk($sformatf("late_c%0d_ismem", c), 64'(tranm.ismem), 1);
            if (c == 1) chk("late_wait_addr", dreq.addr, 64'h8000_0003);
            @(posedge clk); #1;
            chk($sformatf("late_c%0d_bubble", c), 64'(dataM.valid), 0);
        end
        chk("late_stall_cycles", 64'(cnt), 2);
        chk("late_tranm_data", tranm.data, 64'hFFFF_FFFF_FFFF_FF80);
        e.result = 64'hFFFF_FFFF_FFFF_FF80; e.err = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        pop_check("late_dataM");

        // completion while writeback is stalled parks the beat in HOLD
        drive_e(1, OP_ALU, 0, 64'h55, 0, 1, 4, 0);
        e.result = 64'h55; e.err = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_check("hold_pre_dataM");
        drive_e(1, OP_LD, 3'b110, 64'h8000_0004, 0, 1, 8, 0);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h8000_0001_1234_5678;
        stopw         = 1'b1;
        #1;
        chk("hold_issue_dreq_valid", 64'(dreq.valid), 1);
        chk("hold_issue_stopm", 64'(stopm), 1);
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        dresp.data    = 64'hDEAD_DEAD_DEAD_DEAD;
        #1;
        chk("hold_dreq_valid", 64'(dreq.valid), 0);
        chk("hold_stopm", 64'(stopm), 1);
        chk("hold_dataM_result", dataM.result, 64'h55);
        chk("hold_dataM_valid", 64'(dataM.valid), 1);
        @(posedge clk); #1;
        chk("hold2_dreq_valid", 64'(dreq.valid), 0);
        chk("hold2_dataM_result", dataM.result, 64'h55);
        stopw = 1'b0;
        #1;
        chk("hold_release_stopm", 64'(stopm), 0);
        chk("hold_release_tranm", tranm.data, 64'h0000_0000_8000_0001);
        e.result = 64'h0000_0000_8000_0001; e.err = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        pop_check("hold_dataM");

        // reset while waiting on the bus; a stray data_ok afterwards is ignored
        drive_e(1, OP_LD, 3'b011, 64'h8000_0020, 0, 1, 2, 0);
        dresp.data = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        chk("rstw_wait_dreq_valid", 64'(dreq.valid), 1);
        reset = 1'b1;
        drive_e(0, OP_ALU, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rstw_dreq_valid", 64'(dreq.valid), 0);
        chk("rstw_dataM_valid", 64'(dataM.valid), 0);
        chk("rstw_stopm", 64'(stopm), 0);
        dresp.data_ok = 1'b1;
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        #1;
        chk("rstw_late_dataM_valid", 64'(dataM.valid), 0);
        chk("rstw_late_dreq_valid", 64'(dreq.valid), 0);
        chk("rstw_late_tranm_dst", 64'(tranm.dst), 0);
        drive_e(1, OP_LD, 3'b010, 64'h8000_0024, 0, 1, 2, 0);
        dresp.data    = 64'h8765_4321_0000_0000;
        dresp.data_ok = 1'b1;
        #1;
        chk("rstw_idle_dreq_valid", 64'(dreq.valid), 1);
        chk("rstw_idle_stopm", 64'(stopm), 0);
        e.result = 64'hFFFF_FFFF_8765_4321; e.err = 0;
        sb.push_back(e);
        @(posedge clk); #1;
        dresp.data_ok = 1'b0;
        pop_check("rstw_after_dataM");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute; consumes the execute-stage payload (excute_data_t) and performs loads and stores over the data bus.
- Drives the stall back to execute (stopm) and a forwarding record (tranm).
- Registers a memory_data_t payload for writeback.
- Owns load alignment and extension, store byte-lane strobes, and the data-bus request/response FSM.

Parameters:
- AXI_WIDTH, 64, data-bus width in bits; only 64 is supported.
- ADDR_LSB, 3, log2 of bytes per bus beat; used for lane select.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dataE  in  excute_data_t  execute payload: pc, valid, raw_instr, ctl, dst, rd2, result (address or ALU value), csrdst, csr, error
- stopw  in  1  writeback stall; hold dataM
- dreq  out  dbus_req_t  valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[63:0]
- dataM  out  memory_data_t  execute fields, plus result replaced by load data for loads
- stopm  out  1  stall to execute; execute holds its register while high
- tranm  out  tran_t  forwarding record: data, dst (0 when not writing), ismem

Behaviour:
- Reset: FSM=IDLE; dataM.valid=0; dreq.valid=0; stopm=0; tranm.dst=0.
- Memory op: dataE.valid && dataE.error==0 && ctl.op in {LD,SD}. All other valid ops pass through with zero added latency; the register updates on the next edge unless stalled.
- Size/sign from funct3 = raw_instr[14:12]:
  - 000 B, 001 H, 010 W, 011 D (signed).
  - 100 BU, 101 HU, 110 WU (zero-extended).
  - dreq.size = {0, funct3[1:0]}.
- Addr = dataE.result; off = addr[2:0].
  - Store: dreq.data = rd2 << (off*8); strobe = (B:0x01, H:0x03, W:0x0F, D:0xFF) << off.
  - Load: strobe = 0.
  - Load data: shift dresp.data right by off*8, truncate to size, then sign- or zero-extend to 64 bits.
- FSM IDLE / WAIT / HOLD:
  - IDLE: memory op present → dreq.valid=1 this cycle.
    - data_ok same cycle → capture data, op completes.
    - Otherwise → WAIT.
  - WAIT: dreq.valid=1, addr/size/strobe/data held stable. On data_ok, capture data.
    - stopw=0 → IDLE.
    - stopw=1 → HOLD.
  - HOLD: dreq.valid=0; captured data held until stopw=0 → IDLE.
  - addr_ok is ignored for sequencing; data_ok alone completes a beat.
  - A request, once issued, is never withdrawn.
- stopm = (memory op && !op_done) || stopw, where op_done is data_ok this cycle or state==HOLD.
- dataM register, per clock edge:
  - reset → valid=0.
  - Else if stopw → hold.
  - Else if memory op incomplete → valid=0 (bubble).
  - Else → load dataE fields, with result replaced by load data for LD.
- Same op is never re-issued: after completion, execute advances on the same edge that dataM loads.
- tranm is combinational from the current stage:
  - data = load data if LD completes this cycle, else dataE.result.
  - dst = (ctl.regwrite && valid && error==0) ? dst : 0.
  - ismem = (op==LD) && !op_done, so decode stalls on a pending load.
- Boundaries:
  - dataE.error!=0 → no bus access; error propagates unchanged.
  - Reset during WAIT → FSM=IDLE immediately; any late data_ok is ignored.
  - Back-to-back memory ops: the second issues in the cycle after the first loads into dataM.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: an access not aligned to its size produces no request and completes the same cycle; dataM.error = 4 (load) or 6 (store), valid=1, and tranm.dst=0.
- Undefined: the address is forced aligned by clearing low bits (H:[0], W:[1:0], D:[2:0]) before lane and strobe computation; no error is raised.

Test Plan:
- LD funct3=000, addr 0x8000_0003, dresp.data 0x0000_0000_80FF_0000 with data_ok 2 cycles late → stopm high 2 cycles; dataM.result=0xFFFF_FFFF_FFFF_FF80.
- SD funct3=001, rd2=0xBEEF, addr ...06 → dreq.strobe=0xC0, dreq.data[63:48]=0xBEEF, dreq.size=1.
- LD funct3=110, addr ...04, data 0x8000_0001_xxxx_xxxx, stopw=1 on completion → FSM=HOLD, dataM held; after stopw=0, dataM.result=0x0000_0000_8000_0001.
- Non-memory ALU op with result 0x1234, dst=5 → dataM next cycle, no dreq.valid, stopm=0, tranm.dst=5.
- Reset asserted in WAIT → dreq.valid=0 and dataM.valid=0 next cycle; a data_ok pulse afterwards changes nothing.
- With MEM_MISALIGN_TRAP_EN: LD funct3=010 at addr ...02 → no dreq.valid, dataM.error=4. Without the macro: request addr ...00.
